alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Command-side front end for the alu block: issues ops to it and collects its results.
- Accepts one command at a time over a valid/ready handshake.
- Fetches operand 2 from data memory, drives alu op/in_1/in_2, and waits for alu op_done.
- Optionally writes the result back to memory, then returns data and a status code over a valid/ready response port.

Parameters:
- op_sz, 32, operand/result width; must match alu op_sz.
- addr_sz, 8, data memory address width.
- timeout, 64, max EXEC cycles waiting for alu op_done before aborting.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-low; low at a rising edge resets every register.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE.
- cmd_op  in  4  opcode: add 0, sub 1, mult 2, div 3, or 4, and 5, xor 6, read 7, write 8, left 9, right 10, arith 11.
- cmd_data  in  op_sz  operand 1 (alu in_1); also write data for op 8.
- cmd_addr  in  addr_sz  address of operand 2 and of write-back.
- cmd_wb  in  1  write result back to cmd_addr.
- mem_addr  out  addr_sz  memory address.
- mem_rd_en  out  1  read strobe; data returned next cycle.
- mem_rd_data  in  op_sz  read data, valid the cycle after mem_rd_en.
- mem_wr_en  out  1  single-cycle write strobe.
- mem_wr_data  out  op_sz  write data.
- alu_op  out  4  to alu op.
- alu_in_1  out  op_sz  to alu in_1.
- alu_in_2  out  op_sz  to alu in_2.
- alu_out  in  op_sz  from alu out.
- alu_op_err  in  1  from alu op_err.
- alu_op_done  in  1  from alu op_done.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  op_sz  result.
- rsp_code  out  2  status: 0 ok, 1 op_err, 2 timeout, 3 divide-by-zero.

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, except cmd_ready=1.
  - Captured operands 0; timeout counter 0.
  - Outside EXEC, alu_op=0 (add) and alu_in_1/alu_in_2=0.
- States: IDLE, RD_REQ, RD_WAIT, EXEC, WB, RESP.
- IDLE: accept on cmd_valid&cmd_ready (cycle T); latch op, data, addr, wb.
  - op 12..15 -> RESP with code 1, data 0; no memory access.
  - op 8 -> WB.
  - Else -> RD_REQ.
- RD_REQ (T+1): mem_rd_en=1, mem_addr=addr.
- RD_WAIT (T+2): capture mem_rd_data into opb.
  - op 7 -> RESP, data=opb, code 0; wb ignored.
  - op 3 with opb==0 -> RESP, code 3, data 0; no ALU, no WB.
  - Else -> EXEC.
- EXEC (T+3 onward):
  - Drive alu_op=op, alu_in_1=data, alu_in_2=opb.
  - Single-cycle ops (0,1,4,5,6): sample alu_out on the first EXEC cycle.
  - Multi-cycle ops (2,9,10,11): alu_op_done is ignored on the first EXEC cycle. From the second cycle, the first cycle with alu_op_done=1 captures alu_out.
  - alu_op_err=1 on the sample cycle -> code 1, no WB.
  - The counter increments each EXEC cycle. When it reaches timeout without done -> code 2, data 0, no WB.
  - On success: -> WB if wb, else RESP.
- WB: one cycle of mem_wr_en=1, mem_addr=addr, mem_wr_data=result (cmd_data for op 8); -> RESP.
  - Op 8 writes regardless of cmd_wb; rsp_data=cmd_data.
- RESP: rsp_valid=1; rsp_data/rsp_code stable until rsp_ready. Handshake -> IDLE next cycle.
- cmd_ready=0 outside IDLE; no command queueing.
- Add with wb: rsp_valid first at T+5; without wb at T+4.
- Reset low in any state -> IDLE at that edge, including mid-EXEC and mid-RESP:
  - Pending response dropped.
  - No write issued after the reset edge.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- Arithmetic is performed entirely by alu; the sequencer does no width extension.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams 0..11, matching alu;
  - rsp_code constants OK/OPERR/TIMEOUT/DIVZ;
  - state encoding.
- No sub-module: the FSM and timeout counter stay in one module.
- alu is instantiated beside alu_sequencer at the next level up, not inside it.

Test Plan:
- mem[0x10]=5; cmd op=0, data=7, addr=0x10, wb=1 -> mem write 0x10<=12 at T+4; rsp_valid at T+5, data=12, code 0.
- op=2, data=6, mem[0x20]=7, alu model done 4 cycles after op applied, wb=0 -> rsp data=42, code 0; alu_op=2 held through EXEC.
- op=3, mem[0x30]=0 -> rsp code 3, data 0; alu_op never 3; no mem_wr_en.
- op=9, alu model never asserts done -> rsp code 2 after 64 EXEC cycles; no write. Separately, op=13 -> rsp code 1 at T+1, no mem access.
- Backpressure: rsp_ready low 3 cycles -> rsp_data/code stable, cmd_ready=0; IDLE one cycle after handshake.
- Reset low in 2nd EXEC cycle of a multiply with wb=1 -> next cycle cmd_ready=1, rsp_valid=0; no mem_wr_en ever issued.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the alu command sequencer: opcodes, response codes,
// FSM state encoding and opcode classification.
package alu_pkg;

  // Opcodes, matching the alu block.
  localparam logic [3:0] OpAdd   = 4'd0;
  localparam logic [3:0] OpSub   = 4'd1;
  localparam logic [3:0] OpMult  = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpOr    = 4'd4;
  localparam logic [3:0] OpAnd   = 4'd5;
  localparam logic [3:0] OpXor   = 4'd6;
  localparam logic [3:0] OpRead  = 4'd7;
  localparam logic [3:0] OpWrite = 4'd8;
  localparam logic [3:0] OpLeft  = 4'd9;
  localparam logic [3:0] OpRight = 4'd10;
  localparam logic [3:0] OpArith = 4'd11;

  // Response status codes.
  localparam logic [1:0] RspOk      = 2'd0;
  localparam logic [1:0] RspOpErr   = 2'd1;
  localparam logic [1:0] RspTimeout = 2'd2;
  localparam logic [1:0] RspDivZero = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StExec,
    StWb,
    StResp
  } seq_state_e;

  typedef enum logic [2:0] {
    ClsSingle,
    ClsMulti,
    ClsRead,
    ClsWrite,
    ClsIllegal
  } op_class_e;

  // Divide is treated as multi-cycle: the alu signals completion with op_done.
  function automatic op_class_e op_class(input logic [3:0] op);
    op_class_e cls;
    case (op)
      OpAdd, OpSub, OpOr, OpAnd, OpXor:          cls = ClsSingle;
      OpMult, OpDiv, OpLeft, OpRight, OpArith:   cls = ClsMulti;
      OpRead:                                    cls = ClsRead;
      OpWrite:                                   cls = ClsWrite;
      default:                                   cls = ClsIllegal;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Command front end for the alu: fetches operand 2 from memory, runs the op on
// the external alu, optionally writes the result back, and returns a response.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned op_sz   = 32,
  parameter int unsigned addr_sz = 8,
  parameter int unsigned timeout = 64
) (
  input  logic               clk,
  input  logic               reset,
  // Command port
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [op_sz-1:0]   cmd_data,
  input  logic [addr_sz-1:0] cmd_addr,
  input  logic               cmd_wb,
  // Data memory
  output logic [addr_sz-1:0] mem_addr,
  output logic               mem_rd_en,
  input  logic [op_sz-1:0]   mem_rd_data,
  output logic               mem_wr_en,
  output logic [op_sz-1:0]   mem_wr_data,
  // alu
  output logic [3:0]         alu_op,
  output logic [op_sz-1:0]   alu_in_1,
  output logic [op_sz-1:0]   alu_in_2,
  input  logic [op_sz-1:0]   alu_out,
  input  logic               alu_op_err,
  input  logic               alu_op_done,
  // Response port
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [op_sz-1:0]   rsp_data,
  output logic [1:0]         rsp_code
);

  localparam int unsigned CntW = $clog2(timeout + 1);

  seq_state_e         state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [op_sz-1:0]   data_q, data_d;
  logic [addr_sz-1:0] addr_q, addr_d;
  logic               wb_q, wb_d;
  logic [op_sz-1:0]   opb_q, opb_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [op_sz-1:0]   result_q, result_d;
  logic [1:0]         code_q, code_d;

  op_class_e       cmd_cls, exec_cls;
  logic [CntW-1:0] cnt_inc;
  logic            sample;

  assign cmd_cls  = op_class(cmd_op);
  assign exec_cls = op_class(op_q);

  // Next-state and output decode; outputs are zero unless the state drives them.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    addr_d   = addr_q;
    wb_d     = wb_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    code_d   = code_q;

    cmd_ready   = 1'b0;
    mem_addr    = '0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    alu_op      = OpAdd;
    alu_in_1    = '0;
    alu_in_2    = '0;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    rsp_code    = RspOk;

    cnt_inc = cnt_q + CntW'(1);
    sample  = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          addr_d = cmd_addr;
          wb_d   = cmd_wb;
          cnt_d  = '0;
          if (cmd_cls == ClsIllegal) begin
            result_d = '0;
            code_d   = RspOpErr;
            state_d  = StResp;
          end else if (cmd_cls == ClsWrite) begin
            result_d = cmd_data;
            code_d   = RspOk;
            state_d  = StWb;
          end else begin
            state_d = StRdReq;
          end
        end
      end

      StRdReq: begin
        mem_rd_en = 1'b1;
        mem_addr  = addr_q;
        state_d   = StRdWait;
      end

      StRdWait: begin
        opb_d = mem_rd_data;
        if (exec_cls == ClsRead) begin
          result_d = mem_rd_data;
          code_d   = RspOk;
          state_d  = StResp;
        end else if (op_q == OpDiv && mem_rd_data == '0) begin
          result_d = '0;
          code_d   = RspDivZero;
          state_d  = StResp;
        end else begin
          cnt_d   = '0;
          state_d = StExec;
        end
      end

      StExec: begin
        alu_op   = op_q;
        alu_in_1 = data_q;
        alu_in_2 = opb_q;
        // Multi-cycle ops may still show a stale op_done on the first cycle.
        sample   = (exec_cls == ClsMulti) ? (cnt_q != '0 && alu_op_done) : 1'b1;
        cnt_d    = cnt_inc;
        if (sample) begin
          if (alu_op_err) begin
            result_d = '0;
            code_d   = RspOpErr;
            state_d  = StResp;
          end else begin
            result_d = alu_out;
            code_d   = RspOk;
            state_d  = wb_q ? StWb : StResp;
          end
        end else if (cnt_inc == CntW'(timeout)) begin
          result_d = '0;
          code_d   = RspTimeout;
          state_d  = StResp;
        end
      end

      StWb: begin
        mem_wr_en   = 1'b1;
        mem_addr    = addr_q;
        mem_wr_data = result_q;
        state_d     = StResp;
      end

      StResp: begin
        rsp_valid = 1'b1;
        rsp_data  = result_q;
        rsp_code  = code_q;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and captured-operand registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      wb_q     <= 1'b0;
      opb_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      code_q   <= RspOk;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      wb_q     <= wb_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      code_q   <= code_d;
    end
  end

endmodule
